chess_clock_timer_master: RTL and testbench
===========================================

# chess_clock_timer_master

Avalon-MM master that drives the SoC interval timer's 16-bit halfword register map to run a two-player chess clock. It programs the timer period, starts it in continuous/interrupt mode, services each timer interrupt with a status read and clear, and decrements the active player's remaining seconds. It sits between game-control logic (start/toggle/pause pulses) and the timer slave, and presents per-player time and flag outputs to the display path.

## Interface
- `PERIOD_TICKS`, 32'd49_999_999 — timer reload value (ticks per second minus 1); written as four halfwords.
- `INIT_SECS`, 16'd600 — per-player seconds loaded on reset and on `start`.
- `INCREMENT_SECS`, 16'd5 — per-move bonus; used only with `CHESS_CLOCK_INCREMENT_EN`.
- `clk` in 1 — single clock, shared with the timer.
- `reset` in 1 — synchronous, active-high.
- `start` in 1 — pulse; (re)initialise times and program/start timer.
- `toggle` in 1 — pulse; active player ends move.
- `pause` in 1 — level; high stops timer, falling edge resumes.
- `timer_irq` in 1 — timer interrupt (level).
- `avm_address` out 4 — halfword register index.
- `avm_chipselect` out 1 — bus access strobe.
- `avm_write_n` out 1 — 0 = write.
- `avm_writedata` out 16 — write data.
- `avm_readdata` in 16 — registered read data, valid the cycle after address.
- `white_secs`, `black_secs` out 16 — remaining seconds.
- `active_player` out 1 — 0 white, 1 black.
- `flag_white`, `flag_black` out 1 — sticky time-out flags.
- `busy` out 1 — high in any state except IDLE, RUN, PAUSED, FLAGGED.

## Operation
- Register map: 0 status (bit0 TO, write clears), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2–5 period halfwords 0–3.
- Bus rules: one access per cycle, no waitrequest; writes complete in the strobe cycle; read = one cycle `chipselect=1, write_n=1`, data sampled next cycle. Idle bus: `chipselect=0, write_n=1`.
- States: IDLE → (start) CFG_P0..CFG_P3 → CFG_CTRL → RUN. RUN: irq → RD_STAT → CHK_STAT → (TO=1) CLR_STAT → DEC → RUN / FLAGGED; (TO=0) → RUN. RUN: pause → STOP_W → PAUSED; PAUSED: pause low → CFG_CTRL → RUN. FLAGGED: start → CFG_P0.
- CFG_Pn writes halfword n of `PERIOD_TICKS` to address 2+n; CFG_CTRL writes 16'h0007 to address 1. STOP_W and timeout both write 16'h0008 to address 1.
- DEC: active player's seconds −1, saturating at 0; reaching 0 sets that flag, writes stop, enters FLAGGED.
- `toggle` accepted in RUN/PAUSED; flips `active_player`. In other states it is latched (one deep) and applied on next RUN entry.
- `start` honoured only in IDLE/FLAGGED; reloads both times to `INIT_SECS`, clears flags, white active.

## Timing
- Reset: all outputs as idle bus, address 0, writedata 0, times `INIT_SECS`, active_player 0, flags 0, busy 0, state IDLE.
- start → first period write next cycle; timer running after 5 write cycles.
- irq in RUN → time updated 4 cycles later (RD, CHK, CLR, DEC); irq ignored the cycle after CLR_STAT.
- toggle and irq in the same RUN cycle: tick charged to the player active before the toggle; toggle then applied.
- pause and irq in the same cycle: irq serviced first, then STOP_W.
- reset mid-sequence: aborts at once; timer left as is, fully reprogrammed on next start.

## Configuration
- `CHESS_CLOCK_INCREMENT_EN`: defined — each accepted toggle adds `INCREMENT_SECS` to the player who just moved (saturating at 16'hFFFF), not applied if that player is flagged. Undefined — toggle only flips `active_player`; no increment logic.

## Test plan
- Reset then start, `PERIOD_TICKS`=9: writes (2,0009),(3,0000),(4,0000),(5,0000),(1,0007) on consecutive cycles, busy high 5 cycles.
- Model timer fires irq, status reads 0001: write (0,xxxx) seen, white_secs 600→599 four cycles after irq.
- Spurious irq, status reads 0000: no clear write, times unchanged, return to RUN.
- INIT_SECS=2, two ticks on white: white_secs 0, flag_white=1, write (1,0008), state FLAGGED; further irqs ignored.
- Toggle same cycle as irq: white decremented, then active_player=1; with increment macro white ends 600−1+5=604.
- Pause high mid-RUN: write (1,0008); pause low: write (1,0007); times held in between.

Source files
------------

// File: rtl/chess_clock_timer_master.sv
// Avalon-MM master running a two-player chess clock on the SoC interval timer.
// Optional per-move bonus: define CHESS_CLOCK_INCREMENT_EN.
module chess_clock_timer_master #(
    parameter logic [31:0] PERIOD_TICKS   = 32'd49_999_999,
    parameter logic [15:0] INIT_SECS      = 16'd600,
    parameter logic [15:0] INCREMENT_SECS = 16'd5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        toggle,
    input  logic        pause,
    input  logic        timer_irq,
    output logic [3:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    input  logic [15:0] avm_readdata,
    output logic [15:0] white_secs,
    output logic [15:0] black_secs,
    output logic        active_player,
    output logic        flag_white,
    output logic        flag_black,
    output logic        busy
);

    typedef enum logic [3:0] {
        StIdle, StCfgP0, StCfgP1, StCfgP2, StCfgP3, StCfgCtrl, StRun, StRdStat,
        StChkStat, StClrStat, StDec, StStopW, StPaused, StFlagged
    } state_t;

    localparam logic [63:0] PERIOD64 = {32'd0, PERIOD_TICKS};

    state_t      state;
    logic [21:0] bus;
    logic        toggle_pend;
    logic        toggle_req;
    logic        act_flag;
    logic        enter_run;
    logic        do_toggle;
    logic        unused_bits;

    // Bus word is {chipselect, write_n, address, writedata}; it shows the access of the current state.
    assign {avm_chipselect, avm_write_n, avm_address, avm_writedata} = bus;

    function automatic logic [21:0] wr(input logic [3:0] addr, input logic [15:0] data);
        return {1'b1, 1'b0, addr, data};
    endfunction

`ifdef CHESS_CLOCK_INCREMENT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        logic [16:0] s;
        s = {1'b0, v} + {1'b0, INCREMENT_SECS};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction
    assign unused_bits = ^avm_readdata[15:1];
`else
    assign unused_bits = ^{avm_readdata[15:1], INCREMENT_SECS};
`endif

    assign busy       = !(state inside {StIdle, StRun, StPaused, StFlagged});
    assign toggle_req = toggle | toggle_pend;
    assign act_flag   = active_player ? flag_black : flag_white;
    assign enter_run  = (state == StCfgCtrl) || (state == StChkStat && !avm_readdata[0])
                      || (state == StDec && !act_flag);
    // A toggle coinciding with an irq waits until the tick has been charged.
    assign do_toggle  = toggle_req && (enter_run || state == StPaused
                      || (state == StRun && !timer_irq));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= StIdle;
            bus           <= {1'b0, 1'b1, 4'd0, 16'd0};
            white_secs    <= INIT_SECS;
            black_secs    <= INIT_SECS;
            active_player <= 1'b0;
            flag_white    <= 1'b0;
            flag_black    <= 1'b0;
            toggle_pend   <= 1'b0;
        end else begin
            bus         <= {1'b0, 1'b1, bus[19:0]};
            toggle_pend <= toggle_req & ~do_toggle;
            if (do_toggle) begin
                active_player <= ~active_player;
`ifdef CHESS_CLOCK_INCREMENT_EN
                if (!active_player && !flag_white) white_secs <= sat_inc(white_secs);
                if (active_player && !flag_black)  black_secs <= sat_inc(black_secs);
`endif
            end
            case (state)
                StIdle, StFlagged: begin
                    if (start) begin
                        state         <= StCfgP0;
                        bus           <= wr(4'd2, PERIOD64[15:0]);
                        white_secs    <= INIT_SECS;
                        black_secs    <= INIT_SECS;
                        active_player <= 1'b0;
                        flag_white    <= 1'b0;
                        flag_black    <= 1'b0;
                        toggle_pend   <= 1'b0;
                    end
                end
                StCfgP0: begin state <= StCfgP1; bus <= wr(4'd3, PERIOD64[31:16]); end
                StCfgP1: begin state <= StCfgP2; bus <= wr(4'd4, PERIOD64[47:32]); end
                StCfgP2: begin state <= StCfgP3; bus <= wr(4'd5, PERIOD64[63:48]); end
                StCfgP3: begin state <= StCfgCtrl; bus <= wr(4'd1, 16'h0007); end
                StCfgCtrl: state <= StRun;
                StRun: begin
                    if (timer_irq) begin
                        state <= StRdStat;
                        bus   <= {1'b1, 1'b1, 4'd0, 16'd0};
                    end else if (pause) begin
                        state <= StStopW;
                        bus   <= wr(4'd1, 16'h0008);
                    end
                end
                StRdStat: state <= StChkStat;
                StChkStat: begin
                    if (avm_readdata[0]) begin
                        state <= StClrStat;
                        bus   <= wr(4'd0, 16'h0000);
                    end else begin
                        state <= StRun;
                    end
                end
                StClrStat: begin
                    state <= StDec;
                    if (active_player) begin
                        if (black_secs <= 16'd1) begin
                            black_secs <= '0;
                            flag_black <= 1'b1;
                            bus        <= wr(4'd1, 16'h0008);
                        end else begin
                            black_secs <= black_secs - 16'd1;
                        end
                    end else begin
                        if (white_secs <= 16'd1) begin
                            white_secs <= '0;
                            flag_white <= 1'b1;
                            bus        <= wr(4'd1, 16'h0008);
                        end else begin
                            white_secs <= white_secs - 16'd1;
                        end
                    end
                end
                StDec: state <= act_flag ? StFlagged : StRun;
                StStopW: state <= StPaused;
                StPaused: begin
                    if (!pause) begin
                        state <= StCfgCtrl;
                        bus   <= wr(4'd1, 16'h0007);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_chess_clock_timer_master.sv
// Bench for chess_clock_timer_master: vector table for RUN events plus a scoreboard of bus writes.
module tb_chess_clock_timer_master;

    localparam logic [31:0] PTICKS = 32'h0003_0009;
    localparam logic [15:0] INIT   = 16'd4;
`ifdef CHESS_CLOCK_INCREMENT_EN
    localparam int INC = 5;
`else
    localparam int INC = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        toggle = 1'b0;
    logic        pause = 1'b0;
    logic        timer_irq = 1'b0;
    logic [3:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata = '0;
    logic [15:0] white_secs;
    logic [15:0] black_secs;
    logic        active_player;
    logic        flag_white;
    logic        flag_black;
    logic        busy;
    logic [15:0] status_val = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_reads  = 0;
    logic [19:0] exp_q[$];

    typedef struct {
        logic        tog;
        logic        irq;
        logic        st;
        logic [15:0] w;
        logic [15:0] b;
        logic        a;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    chess_clock_timer_master #(
        .PERIOD_TICKS  (PTICKS),
        .INIT_SECS     (INIT),
        .INCREMENT_SECS(16'd5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .toggle        (toggle),
        .pause         (pause),
        .timer_irq     (timer_irq),
        .avm_address   (avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n   (avm_write_n),
        .avm_writedata (avm_writedata),
        .avm_readdata  (avm_readdata),
        .white_secs    (white_secs),
        .black_secs    (black_secs),
        .active_player (active_player),
        .flag_white    (flag_white),
        .flag_black    (flag_black),
        .busy          (busy)
    );

    // Timer slave model: status read returns data the cycle after the strobe.
    always @(posedge clk) begin
        if (avm_chipselect && avm_write_n && avm_address == 4'd0) avm_readdata <= status_val;
    end

    // Write monitor: every bus write must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!reset && avm_chipselect) begin
            if (avm_write_n) begin
                n_reads++;
            end else begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bus_write: got unexpected (%0h,%04h) required none",
                             avm_address, avm_writedata);
                end else begin
                    logic [19:0] e;
                    e = exp_q.pop_front();
                    if ({avm_address, avm_writedata} !== e) begin
                        n_fail++;
                        $display("FAIL bus_write: got (%0h,%04h) required (%0h,%04h)",
                                 avm_address, avm_writedata, e[19:16], e[15:0]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_cfg();
        exp_q.push_back({4'd2, PTICKS[15:0]});
        exp_q.push_back({4'd3, PTICKS[31:16]});
        exp_q.push_back({4'd4, 16'h0000});
        exp_q.push_back({4'd5, 16'h0000});
        exp_q.push_back({4'd1, 16'h0007});
    endtask

    // One-cycle irq/toggle pulse in RUN, then let the service sequence finish.
    task automatic service(input logic tog, input logic irq, input logic st, input logic stop);
        toggle     = tog;
        timer_irq  = irq;
        status_val = {15'd0, st};
        if (irq && st) exp_q.push_back({4'd0, 16'h0000});
        if (stop) exp_q.push_back({4'd1, 16'h0008});
        step(1);
        toggle    = 1'b0;
        timer_irq = 1'b0;
        step(6);
    endtask

    initial begin
        int reads0;
        logic [15:0] exp_b;

        vecs[0] = '{1'b0, 1'b1, 1'b1, 16'd3, 16'd4, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'd3, 16'd4, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 16'(3 + INC), 16'd4, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 16'(3 + INC), 16'(3 + INC), 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 16'(3 + 2 * INC), 16'(3 + INC), 1'b1};

        step(3);
        check("rst_cs", avm_chipselect, 1'b0);
        check("rst_wn", avm_write_n, 1'b1);
        check("rst_addr", avm_address, 4'd0);
        check("rst_wdata", avm_writedata, 16'd0);
        check("rst_white", white_secs, INIT);
        check("rst_black", black_secs, INIT);
        check("rst_active", active_player, 1'b0);
        check("rst_flags", {flag_white, flag_black}, 2'b00);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        step(1);

        start = 1'b1;
        push_cfg();
        step(1);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("cfg_busy", busy, 1'b1);
            step(1);
        end
        check("run_busy", busy, 1'b0);
        check("cfg_queue", exp_q.size(), 0);

        for (int i = 0; i < 5; i++) begin
            reads0 = n_reads;
            service(vecs[i].tog, vecs[i].irq, vecs[i].st, 1'b0);
            check("vec_white", white_secs, vecs[i].w);
            check("vec_black", black_secs, vecs[i].b);
            check("vec_active", active_player, vecs[i].a);
            check("vec_busy", busy, 1'b0);
            check("vec_reads", n_reads - reads0, vecs[i].irq);
        end

        // Latency of a tick on black: visible in the DEC cycle, not before.
        timer_irq  = 1'b1;
        status_val = 16'h0001;
        exp_q.push_back({4'd0, 16'h0000});
        step(1);
        timer_irq = 1'b0;
        check("rd_strobe", {avm_chipselect, avm_write_n, avm_address}, {2'b11, 4'd0});
        step(2);
        check("lat_before", black_secs, 16'(3 + INC));
        check("lat_busy", busy, 1'b1);
        step(1);
        check("lat_after", black_secs, 16'(2 + INC));
        step(3);
        check("lat_idle", busy, 1'b0);

        // Pause: stop written, irqs ignored, then restart written.
        pause = 1'b1;
        exp_q.push_back({4'd1, 16'h0008});
        step(2);
        check("pause_busy", busy, 1'b0);
        reads0    = n_reads;
        timer_irq = 1'b1;
        step(3);
        timer_irq = 1'b0;
        check("pause_reads", n_reads - reads0, 0);
        check("pause_black", black_secs, 16'(2 + INC));
        check("pause_white", white_secs, 16'(3 + 2 * INC));
        pause = 1'b0;
        exp_q.push_back({4'd1, 16'h0007});
        step(3);
        check("resume_busy", busy, 1'b0);
        check("resume_queue", exp_q.size(), 0);

        // Pause and irq together: tick serviced, then stop.
        reads0     = n_reads;
        pause      = 1'b1;
        timer_irq  = 1'b1;
        status_val = 16'h0001;
        exp_q.push_back({4'd0, 16'h0000});
        exp_q.push_back({4'd1, 16'h0008});
        step(1);
        timer_irq = 1'b0;
        step(8);
        check("pirq_black", black_secs, 16'(1 + INC));
        check("pirq_reads", n_reads - reads0, 1);
        check("pirq_queue", exp_q.size(), 0);
        check("pirq_busy", busy, 1'b0);
        pause = 1'b0;
        exp_q.push_back({4'd1, 16'h0007});
        step(3);

        // Run black down to zero.
        exp_b = 16'(1 + INC);
        for (int k = 0; k < 20; k++) begin
            if (exp_b != 16'd0) begin
                service(1'b0, 1'b1, 1'b1, exp_b == 16'd1);
                exp_b = exp_b - 16'd1;
            end
        end
        check("flag_black_secs", black_secs, 16'd0);
        check("flag_black", flag_black, 1'b1);
        check("flag_white", flag_white, 1'b0);
        check("flag_busy", busy, 1'b0);
        check("flag_queue", exp_q.size(), 0);

        reads0    = n_reads;
        timer_irq = 1'b1;
        toggle    = 1'b1;
        step(1);
        toggle = 1'b0;
        step(2);
        timer_irq = 1'b0;
        step(2);
        check("flagged_reads", n_reads - reads0, 0);
        check("flagged_black", black_secs, 16'd0);

        start = 1'b1;
        push_cfg();
        step(1);
        start = 1'b0;
        step(6);
        check("restart_white", white_secs, INIT);
        check("restart_black", black_secs, INIT);
        check("restart_flags", {flag_white, flag_black}, 2'b00);
        check("restart_active", active_player, 1'b0);
        check("restart_busy", busy, 1'b0);
        check("final_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
